// File: rtl/preprocess_sequencer_pkg.sv
// preprocess_pkg: shared sequencer states, beat geometry and default DDR3 base address
package preprocess_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, FILTER, DRAIN, WRITE, DONE} state_t;
    localparam int PIXELS_PER_BEAT = 4;
    localparam logic [31:0] DEFAULT_AXI_BASE_ADDR = 32'h8000_0000;
    function automatic int num_beats(input int pixels);
        return (pixels + PIXELS_PER_BEAT - 1) / PIXELS_PER_BEAT;
    endfunction
endpackage

// File: rtl/preprocess_sequencer_if.sv
// preprocess_sequencer_if: Gaussian buffer read port plus write-only AXI-lite-style channel
interface preprocess_sequencer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic                  buf_rd_en;
    logic [ADDR_WIDTH-1:0] buf_rd_addr;
    logic [DATA_WIDTH-1:0] buf_rd_data;
    logic [31:0]           axi_awaddr;
    logic [31:0]           axi_wdata;
    logic                  axi_wvalid;
    logic                  axi_wready;
    modport master (
        output buf_rd_en, buf_rd_addr, axi_awaddr, axi_wdata, axi_wvalid,
        input  buf_rd_data, axi_wready
    );
    modport slave (
        input  buf_rd_en, buf_rd_addr, axi_awaddr, axi_wdata, axi_wvalid,
        output buf_rd_data, axi_wready
    );
endinterface

// File: rtl/preprocess_sequencer_packer.sv
// pixel_word_packer: packs pixels little-endian into a beat word; a short last word stays zero-filled
module pixel_word_packer
    import preprocess_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [DATA_WIDTH-1:0]                 pixel,
    input  logic                                  pixel_valid,
    input  logic                                  pixel_last,
    input  logic                                  word_ack,
    output logic [PIXELS_PER_BEAT*DATA_WIDTH-1:0] word,
    output logic                                  word_valid
);
    logic [1:0] idx;
    // Clearing on ack means unfilled lanes of the final word are already zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word       <= '0;
            idx        <= '0;
            word_valid <= 1'b0;
        end else if (word_ack) begin
            word       <= '0;
            idx        <= '0;
            word_valid <= 1'b0;
        end else if (pixel_valid) begin
            word[DATA_WIDTH*idx +: DATA_WIDTH] <= pixel;
            idx                                <= idx + 2'd1;
            word_valid                         <= pixel_last || idx == 2'(PIXELS_PER_BEAT - 1);
        end
    end
endmodule

// File: rtl/preprocess_sequencer.sv
// preprocess_sequencer: kick loader, await Gaussian frame end, drain buffer to DDR3 at 4 pixels/beat.
// Optional macro PREPROC_CYCLE_CNT_EN adds the cycle_count port (accepted start to done, saturating).
module preprocess_sequencer
    import preprocess_pkg::*;
#(
    parameter int          IMG_PIXELS     = 784,
    parameter int          ADDR_WIDTH     = 10,
    parameter int          DATA_WIDTH     = 8,
    parameter logic [31:0] AXI_BASE_ADDR  = DEFAULT_AXI_BASE_ADDR,
    parameter int          TIMEOUT_CYCLES = 8192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  load_start,
    input  logic                  load_done,
    input  logic                  gauss_frame_end,
`ifdef PREPROC_CYCLE_CNT_EN
    output logic [31:0]           cycle_count,
`endif
    preprocess_sequencer_if.master bus
);
    localparam int NB = num_beats(IMG_PIXELS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(NB + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_PIXELS - 1);

    state_t                      state, state_nx;
    logic [TW-1:0]               tcnt;
    logic [BW-1:0]               beat;
    logic [ADDR_WIDTH-1:0]       rd_addr;
    logic [2:0]                  issued;
    logic                        all_issued, rd_vld, rd_last, word_valid;
    logic                        accept, issue, beat_ack, timeout, abort;
    logic [4*DATA_WIDTH-1:0]     word;

    assign accept   = state == IDLE && start;
    assign issue    = state == DRAIN && issued != 3'(PIXELS_PER_BEAT) && !all_issued;
    assign beat_ack = state == WRITE && bus.axi_wready;
    assign timeout  = tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign abort    = (state == LOAD || state == FILTER) && state_nx == IDLE;

    always_comb begin
        state_nx         = state;
        busy             = state != IDLE;
        done             = state == DONE;
        bus.axi_wvalid   = state == WRITE;
        bus.buf_rd_en    = issue;
        bus.buf_rd_addr  = rd_addr;
        bus.axi_wdata    = word;
        bus.axi_awaddr   = state == WRITE ? AXI_BASE_ADDR + (32'(beat) << 2) : '0;
        case (state)
            IDLE:    state_nx = start ? LOAD : IDLE;
            LOAD:    state_nx = load_done ? FILTER : timeout ? IDLE : LOAD;
            FILTER:  state_nx = gauss_frame_end ? DRAIN : timeout ? IDLE : FILTER;
            DRAIN:   state_nx = word_valid ? WRITE : DRAIN;
            WRITE:   state_nx = !bus.axi_wready ? WRITE : beat == BW'(NB - 1) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tcnt       <= '0;
            beat       <= '0;
            rd_addr    <= '0;
            issued     <= '0;
            all_issued <= 1'b0;
            rd_vld     <= 1'b0;
            rd_last    <= 1'b0;
            err        <= 1'b0;
            load_start <= 1'b0;
        end else begin
            state      <= state_nx;
            load_start <= accept;
            err        <= accept ? 1'b0 : err | abort;
            tcnt       <= state_nx != state ? '0 : (state == LOAD || state == FILTER) ? tcnt + 1'b1 : tcnt;
            rd_vld     <= issue;
            rd_last    <= issue && rd_addr == LAST_ADDR;
            if (accept) begin
                rd_addr    <= '0;
                all_issued <= 1'b0;
                issued     <= '0;
                beat       <= '0;
            end else if (beat_ack) begin
                issued <= '0;
                beat   <= beat + 1'b1;
            end else if (issue) begin
                issued     <= issued + 3'd1;
                all_issued <= rd_addr == LAST_ADDR;
                rd_addr    <= rd_addr == LAST_ADDR ? rd_addr : rd_addr + 1'b1;
            end
        end
    end

    pixel_word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel      (bus.buf_rd_data),
        .pixel_valid(rd_vld),
        .pixel_last (rd_last),
        .word_ack   (beat_ack),
        .word       (word),
        .word_valid (word_valid)
    );

`ifdef PREPROC_CYCLE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cycle_count <= '0;
        else if (accept)
            cycle_count <= 32'd1;
        else if (abort)
            cycle_count <= '0;
        else if (busy && state != DONE && cycle_count != '1)
            cycle_count <= cycle_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_preprocess_sequencer.sv
// tb_preprocess_sequencer: random frames on a 784-pixel sequencer and a 9-pixel/64-cycle-timeout one,
// each beat compared with a frame model built from buffer contents.
`timescale 1ns/1ps
module tb_preprocess_sequencer;
    import preprocess_pkg::*;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i [2], load_done_i [2], fe_i [2], wready_i [2];
    logic        busy_o [2], done_o [2], err_o [2], ls_o [2], rd_en_o [2], wvalid_o [2];
    logic [9:0]  rd_addr_o [2];
    logic [31:0] awaddr_o [2], wdata_o [2];
`ifdef PREPROC_CYCLE_CNT_EN
    logic [31:0] ccnt_o [2];
`endif
    logic [7:0]  mem [1024];
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        preprocess_sequencer_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) bus ();
        logic [7:0] rd_q;
        always @(posedge clk) if (bus.buf_rd_en) rd_q <= mem[bus.buf_rd_addr];
        preprocess_sequencer #(
            .IMG_PIXELS(g == 0 ? 784 : 9), .ADDR_WIDTH(10), .DATA_WIDTH(8),
            .AXI_BASE_ADDR(BASE), .TIMEOUT_CYCLES(g == 0 ? 8192 : 64)
        ) dut (
            .clk(clk), .rst_n(rst_n), .start(start_i[g]), .busy(busy_o[g]), .done(done_o[g]),
            .err(err_o[g]), .load_start(ls_o[g]), .load_done(load_done_i[g]),
            .gauss_frame_end(fe_i[g]),
`ifdef PREPROC_CYCLE_CNT_EN
            .cycle_count(ccnt_o[g]),
`endif
            .bus(bus)
        );
        assign bus.axi_wready  = wready_i[g];
        assign bus.buf_rd_data = rd_q;
        assign rd_en_o[g]      = bus.buf_rd_en;
        assign rd_addr_o[g]    = bus.buf_rd_addr;
        assign awaddr_o[g]     = bus.axi_awaddr;
        assign wdata_o[g]      = bus.axi_wdata;
        assign wvalid_o[g]     = bus.axi_wvalid;
    end

    function automatic int npix(input int d);
        return d == 0 ? 784 : 9;
    endfunction

    // Beat b holds pixels 4b..4b+3, pixel 4b in the low byte; pixels past the frame read as zero.
    function automatic logic [31:0] exp_beat(input int d, input int b);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++)
            if (4 * b + k < npix(d)) w[8*k +: 8] = mem[4*b + k];
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int d);
        check("idle_busy", busy_o[d], 0);
        check("idle_done", done_o[d], 0);
        check("idle_err", err_o[d], 0);
        check("idle_load_start", ls_o[d], 0);
        check("idle_rd_en", rd_en_o[d], 0);
        check("idle_rd_addr", rd_addr_o[d], 0);
        check("idle_awaddr", awaddr_o[d], 0);
        check("idle_wdata", wdata_o[d], 0);
        check("idle_wvalid", wvalid_o[d], 0);
`ifdef PREPROC_CYCLE_CNT_EN
        check("idle_cycle_count", ccnt_o[d], 0);
`endif
    endtask

    task automatic run_frame(input int d, input int ld, input int fe, input int pct, input bit poke);
        int b = 0, nrd = 0, cyc = 0, ndone = 0, early_rd = 0, meas = 0;
        logic [31:0] pa = '0, pw = '0;
        bit stalled = 0, poked = 0;
        start_i[d] = 1;
        while (cyc < fe) begin
            tick;
            cyc++;
            start_i[d]     = 0;
            load_done_i[d] = cyc == ld;
            fe_i[d]        = cyc == 2 || cyc == fe;
            early_rd      += int'(rd_en_o[d]);
            if (cyc == 1) begin
                check("load_start_on", ls_o[d], 1);
                check("err_cleared", err_o[d], 0);
            end
            if (cyc == 2) check("load_start_pulse", ls_o[d], 0);
        end
        while (ndone == 0 && cyc < 20000) begin
            tick;
            cyc++;
            fe_i[d]    = 0;
            start_i[d] = 0;
            if (stalled) begin
                check("wvalid_hold", wvalid_o[d], 1);
                check("awaddr_hold", awaddr_o[d], pa);
                check("wdata_hold", wdata_o[d], pw);
            end
            if (rd_en_o[d]) begin
                check("rd_addr", rd_addr_o[d], nrd);
                check("rd_in_write", wvalid_o[d], 0);
                nrd++;
            end
            if (done_o[d]) begin
                ndone++;
                meas = cyc;
                check("beats", b, num_beats(npix(d)));
                check("reads", nrd, npix(d));
                if (poke) start_i[d] = 1;
            end
            wready_i[d] = $urandom_range(99) >= pct;
            if (wvalid_o[d] && wready_i[d]) begin
                check("awaddr", awaddr_o[d], BASE + 32'(4 * b));
                check("wdata", wdata_o[d], exp_beat(d, b));
                b++;
            end
            stalled = wvalid_o[d] && !wready_i[d];
            pa      = awaddr_o[d];
            pw      = wdata_o[d];
            if (poke && b == 2 && !poked) begin
                start_i[d] = 1;
                poked      = 1;
            end
        end
        check("no_read_before_frame_end", early_rd, 0);
        check("done_seen", ndone, 1);
        tick;
        start_i[d]  = 0;
        wready_i[d] = 1;
        check("done_one_cycle", done_o[d], 0);
        check("busy_after_done", busy_o[d], 0);
        repeat (4) tick;
        check("no_restart", busy_o[d], 0);
        check("no_load_start", ls_o[d], 0);
`ifdef PREPROC_CYCLE_CNT_EN
        check("cycle_count", ccnt_o[d], meas);
`endif
    endtask

    initial begin
        int n, nd;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i + 1);
        for (int d = 0; d < 2; d++) begin
            start_i[d]     = 0;
            load_done_i[d] = 0;
            fe_i[d]        = 0;
            wready_i[d]    = 1;
        end
        #2 rst_n = 0;
        repeat (3) tick;
        check_idle(0);
        check_idle(1);
        rst_n = 1;
        tick;
        run_frame(0, 10, 900, 0, 0);
        run_frame(1, 5, 40, 0, 0);
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        run_frame(0, 10, 100, 30, 1);
        run_frame(1, 3, 20, 30, 1);
        // Loader never answers: the small instance must give up after its 64-cycle budget.
        n  = 0;
        nd = 0;
        start_i[1] = 1;
        repeat (100) begin
            tick;
            start_i[1] = 0;
            n  += int'(busy_o[1]);
            nd += int'(done_o[1]);
        end
        check("timeout_busy_cycles", n, 64);
        check("timeout_err", err_o[1], 1);
        check("timeout_no_done", nd, 0);
`ifdef PREPROC_CYCLE_CNT_EN
        check("timeout_cycle_count", ccnt_o[1], 0);
`endif
        run_frame(1, 4, 30, 50, 0);
        start_i[0] = 1;
        tick;
        start_i[0] = 0;
        repeat (3) tick;
        load_done_i[0] = 1;
        tick;
        load_done_i[0] = 0;
        repeat (3) tick;
        fe_i[0] = 1;
        tick;
        fe_i[0] = 0;
        repeat (30) tick;
        check("busy_before_reset", busy_o[0], 1);
        rst_n = 0;
        #1;
        check_idle(0);
        tick;
        rst_n = 1;
        nd = 0;
        repeat (5) begin
            tick;
            nd += int'(done_o[0]);
        end
        check("abort_no_done", nd, 0);
        check("abort_idle", busy_o[0], 0);
        run_frame(0, 6, 60, 50, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
